// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Opcode constants are kept here so hazard-side logic can share one definition.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    BRL2 = 2'd1,
    MEMW = 2'd2
  } stall_state_t;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: turns hazard flags, branch outcome and memory busy
// into per-stage enables, flushes and bubbles, with multi-cycle stall sequencing.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_load_use,
  input  logic             hz_br_alu,
  input  logic             hz_br_load,
  input  logic             br_taken,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  // Handshake-free block: every output is a per-cycle level, valid in the same
  // cycle as the inputs that cause it; there is no valid/ready flow here.

  stall_state_t      state_q, state_d;
  stall_state_t      ret_q, ret_d;
  stall_state_t      eval_state;
  logic              stall_inc, flush_inc;
  logic [WAIT_W-1:0] wait_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      if (dmem_busy && (wait_q >= WAIT_W'(MAX_WAIT - 1))) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // Leaving a freeze resumes whatever state was interrupted, in the same cycle.
  assign eval_state = (state_q == MEMW) ? ret_q : state_q;

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    state_d       = state_q;
    ret_d         = ret_q;
    if (!rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (dmem_busy) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
      state_d       = MEMW;
      if (state_q != MEMW) ret_d = state_q;
    end else begin
      state_d = RUN;
      case (eval_state)
        BRL2: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          stall_inc    = 1'b1;
        end
        default: begin
          if (hz_load_use || hz_br_alu || hz_br_load) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            if (hz_br_load) state_d = BRL2;
          end else if (br_taken) begin
            if_id_flush = 1'b1;
            flush_inc   = 1'b1;
          end
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk), .rst (rst), .clr (1'b0), .inc (stall_inc), .q (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk), .rst (rst), .clr (1'b0), .inc (flush_inc), .q (flush_cnt)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk (clk), .rst (rst), .clr (!dmem_busy), .inc (dmem_busy), .q (wait_q)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus random traffic, checked
// against a pending-stall reference model; a 4-bit-counter copy checks saturation.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hz_load_use = 1'b0, hz_br_alu = 1'b0, hz_br_load = 1'b0;
  logic br_taken = 1'b0, dmem_busy = 1'b0;

  logic a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_if_id_flush, a_id_ex_bubble, a_mem_wb_bubble;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic a_mem_timeout;
  logic b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_if_id_flush, b_id_ex_bubble, b_mem_wb_bubble;
  logic [3:0] b_stall_cnt, b_flush_cnt;
  logic b_mem_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_pending;
  int m_wait;
  bit m_timeout;
  int m_stall;
  int m_flush;

  localparam logic [6:0] C_RUN    = 7'b1111_000;
  localparam logic [6:0] C_STALL  = 7'b0011_010;
  localparam logic [6:0] C_FLUSH  = 7'b1111_100;
  localparam logic [6:0] C_FREEZE = 7'b0000_001;
  localparam logic [6:0] C_RESET  = 7'b0000_111;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(16), .WAIT_W(8), .MAX_WAIT(200)) dut_a (
    .clk(clk), .rst(rst), .hz_load_use(hz_load_use), .hz_br_alu(hz_br_alu),
    .hz_br_load(hz_br_load), .br_taken(br_taken), .dmem_busy(dmem_busy),
    .pc_en(a_pc_en), .if_id_en(a_if_id_en), .id_ex_en(a_id_ex_en), .ex_mem_en(a_ex_mem_en),
    .if_id_flush(a_if_id_flush), .id_ex_bubble(a_id_ex_bubble), .mem_wb_bubble(a_mem_wb_bubble),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .mem_timeout(a_mem_timeout)
  );

  pipeline_stall_ctrl #(.CNT_W(4), .WAIT_W(8), .MAX_WAIT(200)) dut_b (
    .clk(clk), .rst(rst), .hz_load_use(hz_load_use), .hz_br_alu(hz_br_alu),
    .hz_br_load(hz_br_load), .br_taken(br_taken), .dmem_busy(dmem_busy),
    .pc_en(b_pc_en), .if_id_en(b_if_id_en), .id_ex_en(b_id_ex_en), .ex_mem_en(b_ex_mem_en),
    .if_id_flush(b_if_id_flush), .id_ex_bubble(b_id_ex_bubble), .mem_wb_bubble(b_mem_wb_bubble),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .mem_timeout(b_mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic check_all(input logic [6:0] exp_ctrl);
    check("ctrl_a", {25'd0, a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en,
                     a_if_id_flush, a_id_ex_bubble, a_mem_wb_bubble}, {25'd0, exp_ctrl});
    check("ctrl_b", {25'd0, b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en,
                     b_if_id_flush, b_id_ex_bubble, b_mem_wb_bubble}, {25'd0, exp_ctrl});
    check("stall_cnt16", {16'd0, a_stall_cnt}, sat(m_stall, 65535));
    check("flush_cnt16", {16'd0, a_flush_cnt}, sat(m_flush, 65535));
    check("stall_cnt4",  {28'd0, b_stall_cnt}, sat(m_stall, 15));
    check("flush_cnt4",  {28'd0, b_flush_cnt}, sat(m_flush, 15));
    check("mem_timeout", {30'd0, a_mem_timeout, b_mem_timeout}, {30'd0, m_timeout, m_timeout});
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_wait    = 0;
    m_timeout = 1'b0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  // One clock cycle: drive, check this cycle's outputs, then advance the model.
  task automatic step(input logic busy, input logic lu, input logic ba,
                      input logic bl, input logic bt);
    logic [6:0] exp_ctrl;
    @(negedge clk);
    dmem_busy = busy; hz_load_use = lu; hz_br_alu = ba; hz_br_load = bl; br_taken = bt;
    #1;
    if (busy) exp_ctrl = C_FREEZE;
    else if (m_pending || lu || ba || bl) exp_ctrl = C_STALL;
    else if (bt) exp_ctrl = C_FLUSH;
    else exp_ctrl = C_RUN;
    check_all(exp_ctrl);
    if (busy) begin
      m_wait++;
      if (m_wait >= 200) m_timeout = 1'b1;
    end else begin
      m_wait = 0;
      if (m_pending) begin
        m_stall++;
        m_pending = 1'b0;
      end else if (lu || ba || bl) begin
        m_stall++;
        m_pending = bl;
      end else if (bt) begin
        m_flush++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    dmem_busy = 1'b0; hz_load_use = 1'b0; hz_br_alu = 1'b0; hz_br_load = 1'b0; br_taken = 1'b0;
    model_reset();
    #1;
    check_all(C_RESET);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all(C_RESET);
    @(negedge clk);
    rst = 1'b1;

    // single load-use stall
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // branch-after-load: two stalls, br_taken ignored in the second
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    // taken branch flush
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    // freeze arriving in BRL2, then the deferred stall
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    // multiple hazards at once
    step(0, 1, 1, 1, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // memory timeout boundary
    for (int i = 0; i < 199; i++) step(1, 0, 0, 0, 0);
    check("timeout_before_200", {31'd0, a_mem_timeout}, 32'd0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("timeout_sticky", {31'd0, a_mem_timeout}, 32'd1);
    step(0, 0, 0, 0, 0);

    // saturation of the 4-bit copy, then reset during a BRL2 cycle
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    check("stall_sat4", {28'd0, b_stall_cnt}, 32'd15);
    step(0, 0, 0, 1, 0);
    do_reset();
    step(0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 12),
           ($urandom_range(0, 99) < 30));
    end
    step(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
